// File: rtl/mem_pkg.sv
// Shared encodings for the data-SRAM access sequencer: load/store opcodes,
// bus size codes, FSM states, and opcode classification helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } ls_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (|op[1:0]);
    endfunction

    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            OP_LW, OP_SW:         return SZ_WORD;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_BYTE;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return |a;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Store lane aligner: replicates the store operand across byte lanes and builds strobes.
// Latency: purely combinational.
// Backpressure: none; sampled by the sequencer only when it accepts an access.
module store_align
    import mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_raw,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [1:0]  size
);

    always_comb begin
        wstrb = 4'b0000;
        wdata = wdata_raw;
        size  = op_size(op);
        case (op)
            OP_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{wdata_raw[7:0]}};
            end
            OP_SH: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wdata_raw[15:0]}};
            end
            OP_SW:   wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-SRAM access sequencer, one load/store at a time; MEM_ADDR_CHECK_EN rejects misaligned ops.
// Latency: accept -> mem_ready 2 cycles minimum, +1 per cycle waiting on addr_ok or data_ok.
// Backpressure: stall holds the pipeline from accept until DONE; data_req held until addr_ok.
module mem_access_ctrl
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic        mem_ready,
    output logic        addr_err,
    output logic [31:0] rdata_wr,
    output logic [2:0]  lsop_wr,
    output logic [1:0]  addr_wr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [1:0]  al_size;
    logic        acc_err;
    logic        accept;

    store_align u_store_align (
        .op        (mem_op),
        .addr_lo   (mem_addr[1:0]),
        .wdata_raw (mem_wdata),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata),
        .size      (al_size)
    );

`ifdef MEM_ADDR_CHECK_EN
    assign acc_err = (state_q == ST_IDLE) & mem_valid & misaligned(mem_op, mem_addr[1:0]);
`else
    assign acc_err = 1'b0;
`endif
    assign accept = (state_q == ST_IDLE) & mem_valid & ~acc_err;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        size_d   = size_q;
        rdata_d  = rdata_q;
        data_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = mem_op;
                    addr_d  = mem_addr;
                    wdata_d = al_wdata;
                    wstrb_d = al_wstrb;
                    size_d  = al_size;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                data_req = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = ST_DONE;
                        if (!is_store(op_q)) rdata_d = data_rdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (data_data_ok) begin
                    state_d = ST_DONE;
                    if (!is_store(op_q)) rdata_d = data_rdata;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The bus transaction is abandoned on reset; the bus side resets with us.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            size_q  <= 2'd0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall      = accept | (state_q == ST_REQ) | (state_q == ST_WAIT);
    assign mem_ready  = (state_q == ST_DONE) | acc_err;
    assign addr_err   = acc_err;
    assign rdata_wr   = rdata_q;
    assign lsop_wr    = op_q;
    assign addr_wr    = addr_q[1:0];
    assign data_wr    = is_store(op_q);
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wstrb = wstrb_q;
    assign data_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboarded bench for mem_access_ctrl: random loads/stores against a byte-lane model,
// with a bus responder injecting random addr_ok/data_ok delays.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall, mem_ready, addr_err;
    logic [31:0] rdata_wr;
    logic [2:0]  lsop_wr;
    logic [1:0]  addr_wr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    mem_access_ctrl dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .mem_ready(mem_ready),
        .addr_err(addr_err), .rdata_wr(rdata_wr), .lsop_wr(lsop_wr), .addr_wr(addr_wr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic        err;
        logic [31:0] rdata_exp;
        int          lat;
        int          icyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ad;
        int          dd;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, done_cnt = 0, issued = 0;
    bit   chk_stall = 1'b0;
    logic [31:0] model_rd = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not expected (cycle %0d)", nm, cyc);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, {stall, mem_ready, addr_err, rdata_wr, lsop_wr, addr_wr, data_req, data_wr,
                 data_size, data_addr, data_wstrb, data_wdata}, 128'h0);
    endtask

    // Model: access width in bytes drives size, strobes, replication and alignment.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ad, input int dd, input bit tog);
        int   nb;
        bit   st, err;
        exp_t e;
        bus_t b;
        int   target;
        nb  = (op == 3'd4 || op == 3'd7) ? 4 : (op == 3'd2 || op == 3'd3 || op == 3'd6) ? 2 : 1;
        st  = (op >= 3'd5);
        err = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
        err = (addr % nb) != 0;
`endif
        b.addr  = addr;
        b.wr    = st;
        b.size  = 2'(nb / 2);
        b.wstrb = !st ? 4'h0 : (nb == 4) ? 4'hF :
                  (nb == 2) ? 4'(4'h3 << (2 * ((addr % 4) / 2))) : 4'(4'h1 << (addr % 4));
        b.wdata = (nb == 1) ? 32'(wdata[7:0] * 32'h01010101) :
                  (nb == 2) ? 32'(wdata[15:0] * 32'h00010001) : wdata;
        b.rdata = rdata;
        b.ad    = ad;
        b.dd    = dd;
        if (!err && !st) model_rd = rdata;
        e.op        = op;
        e.addr      = addr;
        e.err       = err;
        e.rdata_exp = model_rd;
        e.lat       = err ? 0 : 2 + ad + dd;

        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_op    = op;
        mem_addr  = addr;
        mem_wdata = wdata;
        e.icyc    = cyc;
        target    = done_cnt + 1;
        exp_q.push_back(e);
        if (!err) bus_q.push_back(b);
        issued++;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        for (int i = 0; i < 100 && done_cnt < target; i++) begin
            if (tog) begin
                mem_valid = 1'($urandom);
                mem_op    = 3'($urandom);
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
            @(posedge clk); #1;
        end
        mem_valid = 1'b0;
        if (done_cnt < target) flag("ready_timeout");
    endtask

    // Monitor: stall window and write-back fields checked against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_stall;
        if (resetn === 1'b1) begin
            if (chk_stall) begin
                exp_stall = 1'b0;
                if (exp_q.size() > 0 && !exp_q[0].err &&
                    cyc >= exp_q[0].icyc && cyc < exp_q[0].icyc + exp_q[0].lat)
                    exp_stall = 1'b1;
                chk("stall", stall, exp_stall);
            end
            if (mem_ready) begin
                if (exp_q.size() == 0) begin
                    flag("spurious_mem_ready");
                end else begin
                    e = exp_q.pop_front();
                    done_cnt++;
                    chk("latency", cyc - e.icyc, e.lat);
                    chk("addr_err", addr_err, e.err);
                    chk("rdata_wr", rdata_wr, e.rdata_exp);
                    if (!e.err) begin
                        chk("lsop_wr", lsop_wr, e.op);
                        chk("addr_wr", addr_wr, e.addr[1:0]);
                    end
                end
            end else if (addr_err) begin
                flag("addr_err_without_ready");
            end
        end
    end

    // Bus responder: addr_ok after ad cycles of data_req, data_ok dd cycles after that.
    initial begin
        int   ph = 0, ac = 0, dc = 0;
        bus_t b;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        forever begin
            @(posedge clk); #1;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            if (resetn !== 1'b1) begin
                ph = 0;
                continue;
            end
            if (ph == 0 && data_req) begin
                if (bus_q.size() == 0) begin
                    flag("unexpected_data_req");
                end else begin
                    b = bus_q.pop_front();
                    chk("data_addr", data_addr, b.addr);
                    chk("data_wr", data_wr, b.wr);
                    chk("data_size", data_size, b.size);
                    chk("data_wstrb", data_wstrb, b.wstrb);
                    if (b.wr) chk("data_wdata", data_wdata, b.wdata);
                    ac = b.ad;
                    dc = b.dd;
                    ph = 1;
                end
            end else if (ph == 1) begin
                chk("req_held", data_req, 1'b1);
            end else if (ph == 2) begin
                chk("req_dropped", data_req, 1'b0);
            end
            case (ph)
                1: begin
                    if (ac == 0) begin
                        data_addr_ok = 1'b1;
                        if (dc == 0) begin
                            data_data_ok = 1'b1;
                            data_rdata   = b.rdata;
                            ph = 0;
                        end else begin
                            ph = 2;
                        end
                    end else begin
                        ac--;
                    end
                end
                2: begin
                    dc--;
                    if (dc == 0) begin
                        data_data_ok = 1'b1;
                        data_rdata   = b.rdata;
                        ph = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t dummy;
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_op    = 3'd0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_outputs");
        @(posedge clk); #1;
        resetn    = 1'b1;
        chk_stall = 1'b1;

        issue(3'd4, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        issue(3'd5, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);
        issue(3'd6, 32'h0000_2002, 32'h0000_1234, 32'h0, 3, 2, 1'b0);
        issue(3'd2, 32'h0000_1001, 32'h0, 32'h5555_AAAA, 1, 1, 1'b0);
        issue(3'd4, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 1, 4, 1'b1);

        // Reset while the access sits in WAIT.
        chk_stall = 1'b0;
        dummy = '{addr: 32'h3000, wr: 1'b0, size: 2'd2, wstrb: 4'h0, wdata: 32'h0,
                  rdata: 32'h1111_2222, ad: 0, dd: 60};
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_op    = 3'd4;
        mem_addr  = 32'h0000_3000;
        bus_q.push_back(dummy);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_in_wait", stall, 1'b1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_in_wait");
        @(posedge clk); #1;
        resetn    = 1'b1;
        model_rd  = 32'h0;
        bus_q.delete();
        chk_stall = 1'b1;
        issue(3'd4, 32'h0000_5000, 32'h0, 32'hCAFE_0001, 0, 1, 1'b0);

        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom), {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 15)),
                  $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ready_count", done_cnt, issued);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("bus_queue_empty", bus_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
